// File: rtl/mux_rr_reg_pkg.sv
// Shared definitions for the registered fixed / round-robin channel mux.
//   MODE_FIXED / MODE_RR : values of the top-level 'mode' input.
//   clog2()              : index width for a channel count (constant context).
package mux_rr_reg_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Smallest r with 2**r >= v; returns 1 for v <= 2 so an index is never 0 bits.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: finds the first set request starting at ptr and
// wrapping modulo N. Purely combinational.
//   req     : per-channel request bits
//   ptr     : highest-priority channel (expected < N)
//   gnt_idx : winning channel index (0 when gnt_any = 0)
//   gnt_any : at least one request set
module rr_prio_enc #(
  parameter int N    = 16,
  parameter int SELW = 4
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Doubling the vector turns the modulo-N rotation into a plain slice.
  assign dbl = {req, req};

  always_comb begin
    int sum;
    sum     = 0;
    rot     = dbl[ptr +: N];
    gnt_any = |rot;
    gnt_idx = '0;
    // Walk down so the lowest rotated position (nearest ptr) wins last.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = int'(ptr) + j;
        if (sum >= N) sum = sum - N;
        gnt_idx = SELW'(sum);
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// N-channel to one mux with a single registered output stage.
// Selection is either a fixed channel (sel) or round-robin from ptr.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : flat bus, channel k at [k*WIDTH +: WIDTH]
//   in_valid   : per-channel request;   in_ready : one-hot accept
//   mode, sel  : 0 = fixed channel sel, 1 = round-robin
//   out_data, out_ch, out_valid, out_ready : registered output handshake
module mux_rr_reg
  import mux_rr_reg_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 16,
  localparam int SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [N-1:0][WIDTH-1:0] words;
  logic [SELW-1:0]         ptr, ptr_nxt, rr_idx, g;
  logic                    load, fx_ok, rr_any, any, xfer;

  assign words = in_data;

  rr_prio_enc #(.N(N), .SELW(SELW)) u_enc (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Output register is free when empty or being drained this cycle.
  assign load  = !out_valid || out_ready;
  // Out-of-range sel never grants; the extra bit keeps N itself representable.
  assign fx_ok = ({1'b0, sel} < (SELW+1)'(N)) && in_valid[sel];
  assign g     = (mode == MODE_RR) ? rr_idx : sel;
  assign any   = (mode == MODE_RR) ? rr_any : fx_ok;
  assign xfer  = load && any && !rst;

  assign ptr_nxt = ({1'b0, g} == (SELW+1)'(N - 1)) ? '0 : g + SELW'(1);

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      if (xfer && mode == MODE_RR) ptr <= ptr_nxt;
      if (load) begin
        out_valid <= any;
        if (any) begin
          out_data <= words[g];
          out_ch   <= g;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: a 16-channel and a 5-channel instance. Vector tables
// carry the expected grant; the granted word is queued and checked one cycle
// later when it appears on the output register.
module tb_mux_rr_reg;
  import mux_rr_reg_pkg::*;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] data;
  } pkt_t;

  typedef struct {
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] vld;
    logic        ordy;
    int          g;     // expected grant, -1 = none
    logic        expv;  // expected out_valid after the edge
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-channel instance
  logic [15:0][7:0] d16;
  logic [15:0]      vld16, rdy16;
  logic             mode16, ov16, ordy16;
  logic [3:0]       sel16, och16;
  logic [7:0]       od16;

  // 5-channel instance
  logic [4:0][7:0]  d5;
  logic [4:0]       vld5, rdy5;
  logic             mode5, ov5, ordy5;
  logic [2:0]       sel5, och5;
  logic [7:0]       od5;

  mux_rr_reg #(.WIDTH(8), .N(16)) u16 (
    .clk(clk), .rst(rst), .in_data(d16), .in_valid(vld16), .in_ready(rdy16),
    .mode(mode16), .sel(sel16), .out_data(od16), .out_ch(och16),
    .out_valid(ov16), .out_ready(ordy16)
  );

  mux_rr_reg #(.WIDTH(8), .N(5)) u5 (
    .clk(clk), .rst(rst), .in_data(d5), .in_valid(vld5), .in_ready(rdy5),
    .mode(mode5), .sel(sel5), .out_data(od5), .out_ch(och5),
    .out_valid(ov5), .out_ready(ordy5)
  );

  int   nvec = 0;
  int   nerr = 0;
  vec_t tbl[$];
  pkt_t sb[$];
  pkt_t held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic m, input logic [3:0] s, input logic [15:0] v,
                     input logic o, input int g, input logic ev);
    vec_t t;
    t.mode = m; t.sel = s; t.vld = v; t.ordy = o; t.g = g; t.expv = ev;
    tbl.push_back(t);
  endtask

  // Pop the word granted last cycle; an empty queue is itself a failure.
  task automatic pop_expect(input string nm);
    nvec++;
    if (sb.size() == 0) begin
      nerr++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      held = sb.pop_front();
    end
  endtask

  task automatic apply16(input vec_t t);
    logic [15:0] er;
    @(negedge clk);
    mode16 = t.mode; sel16 = t.sel; vld16 = t.vld; ordy16 = t.ordy;
    #1;
    er = (t.g >= 0) ? (16'd1 << t.g) : 16'd0;
    chk("in_ready16", 64'(rdy16), 64'(er));
    if (t.g >= 0) sb.push_back('{ch: 4'(t.g), data: 8'(t.g * 17)});
    @(posedge clk); #1;
    chk("out_valid16", 64'(ov16), 64'(t.expv));
    if (t.g >= 0) pop_expect("sb16");
    if (t.expv) begin
      chk("out_ch16", 64'(och16), 64'(held.ch));
      chk("out_data16", 64'(od16), 64'(held.data));
    end
  endtask

  task automatic apply5(input logic m, input logic [2:0] s, input logic [4:0] v,
                        input logic o, input int g, input logic ev);
    logic [4:0] er;
    @(negedge clk);
    mode5 = m; sel5 = s; vld5 = v; ordy5 = o;
    #1;
    er = (g >= 0) ? (5'd1 << g) : 5'd0;
    chk("in_ready5", 64'(rdy5), 64'(er));
    if (g >= 0) sb.push_back('{ch: 4'(g), data: 8'(g * 17)});
    @(posedge clk); #1;
    chk("out_valid5", 64'(ov5), 64'(ev));
    if (g >= 0) pop_expect("sb5");
    if (ev) begin
      chk("out_ch5", 64'(och5), 64'(held.ch));
      chk("out_data5", 64'(od5), 64'(held.data));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 16; k++) d16[k] = 8'(k * 17);
    for (int k = 0; k < 5; k++)  d5[k]  = 8'(k * 17);
    held   = '0;
    mode16 = MODE_FIXED; sel16 = 4'd7; vld16 = 16'hffff; ordy16 = 1'b1;
    mode5  = MODE_FIXED; sel5  = 3'd0; vld5  = 5'h00;    ordy5  = 1'b1;

    // Reset: no accept while rst is high, registers cleared.
    @(negedge clk); #1;
    chk("rst_in_ready16", 64'(rdy16), 64'h0);
    @(posedge clk); #1;
    chk("rst_out_valid16", 64'(ov16), 64'h0);
    chk("rst_out_data16", 64'(od16), 64'h0);
    chk("rst_out_ch16", 64'(och16), 64'h0);
    chk("rst_out_valid5", 64'(ov5), 64'h0);
    @(negedge clk); rst = 1'b0;

    // Fixed channel 7.
    add(MODE_FIXED, 4'd7, 16'hffff, 1'b1, 7, 1'b1);
    // Round-robin, all valid: 0..15 then 0..3 back to back.
    for (int i = 0; i < 20; i++) add(MODE_RR, 4'd0, 16'hffff, 1'b1, i % 16, 1'b1);
    // Only 3 and 12 valid, ptr starts at 4.
    add(MODE_RR, 4'd0, 16'h1008, 1'b1, 12, 1'b1);
    add(MODE_RR, 4'd0, 16'h1008, 1'b1, 3,  1'b1);
    add(MODE_RR, 4'd0, 16'h1008, 1'b1, 12, 1'b1);
    add(MODE_RR, 4'd0, 16'h1008, 1'b1, 3,  1'b1);
    // Stall: word ch3 held while requests toggle.
    for (int i = 0; i < 5; i++)
      add(MODE_RR, 4'd0, (i % 2) ? 16'hffff : 16'h00f0, 1'b0, -1, 1'b1);
    // Drain with nothing pending: valid falls.
    add(MODE_RR, 4'd0, 16'h0000, 1'b1, -1, 1'b0);
    add(MODE_RR, 4'd0, 16'h0020, 1'b1, 5, 1'b1);        // ptr 4 -> grant 5
    add(MODE_FIXED, 4'd2, 16'hffff, 1'b1, 2, 1'b1);     // mode switch, ptr holds 6
    add(MODE_RR, 4'd0, 16'hffff, 1'b1, 6, 1'b1);        // ptr 6 -> 7
    add(MODE_FIXED, 4'd9, 16'h0200, 1'b0, -1, 1'b1);    // full and stalled
    add(MODE_FIXED, 4'd9, 16'h0200, 1'b1, 9, 1'b1);
    add(MODE_FIXED, 4'd4, 16'hffef, 1'b1, -1, 1'b0);    // sel not valid
    add(MODE_FIXED, 4'd9, 16'h0200, 1'b0, 9, 1'b1);     // empty -> loads despite out_ready=0
    foreach (tbl[i]) apply16(tbl[i]);

    // Reset while a word is held and stalled.
    @(negedge clk);
    rst = 1'b1; mode16 = MODE_FIXED; sel16 = 4'd9; vld16 = 16'hffff; ordy16 = 1'b0;
    #1;
    chk("midrst_in_ready16", 64'(rdy16), 64'h0);
    @(posedge clk); #1;
    chk("midrst_out_valid16", 64'(ov16), 64'h0);
    chk("midrst_out_data16", 64'(od16), 64'h0);
    chk("midrst_out_ch16", 64'(och16), 64'h0);
    @(negedge clk); rst = 1'b0;
    tbl.delete();
    // ptr was 7 before reset; the search must restart at 0.
    add(MODE_RR, 4'd0, 16'h4220, 1'b1, 5, 1'b1);
    add(MODE_RR, 4'd0, 16'h0000, 1'b1, -1, 1'b0);
    foreach (tbl[i]) apply16(tbl[i]);

    // 5-channel instance: out-of-range sel and ptr wrap.
    apply5(MODE_FIXED, 3'd6, 5'h1f, 1'b1, -1, 1'b0);
    apply5(MODE_FIXED, 3'd5, 5'h1f, 1'b1, -1, 1'b0);
    apply5(MODE_FIXED, 3'd4, 5'h1f, 1'b1, 4, 1'b1);
    apply5(MODE_RR,    3'd0, 5'h10, 1'b1, 4, 1'b1);   // ptr 0 -> 4, wraps to 0
    apply5(MODE_RR,    3'd0, 5'h11, 1'b1, 0, 1'b1);   // ptr 0 -> 1
    apply5(MODE_RR,    3'd0, 5'h11, 1'b1, 4, 1'b1);   // ptr 1 -> 4, wraps to 0
    apply5(MODE_RR,    3'd0, 5'h11, 1'b1, 0, 1'b1);
    apply5(MODE_RR,    3'd0, 5'h00, 1'b1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width per channel.
REQ-002 SHALL have parameter N, default 16, channel count (2..64, need not be a power of two).
REQ-003 SHALL have derived parameter SELW = clog2(N), not overridable.
REQ-004 SHALL use a single clock and a synchronous, active-high reset.
REQ-005 Port list, clock and reset first:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_data  input  N*WIDTH  flat bus; channel k at bits [k*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept, at most one bit high.
- mode  input  1  0 = FIXED (use sel), 1 = ROUND_ROBIN.
- sel  input  SELW  channel index in FIXED mode.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  SELW  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_ch hold a word.
- out_ready  input  1  downstream accepts the word.

Function
REQ-006 SHALL define load = !out_valid || out_ready, evaluated in the same cycle.
REQ-007 Grant channel g SHALL transfer when load=1 and in_valid[g]=1; in_ready[g]=1 only in that cycle.
REQ-008 On transfer, out_data/out_ch/out_valid SHALL update at the next edge; latency is 1 cycle; input-to-output throughput is 1 word/cycle when out_ready stays 1.
REQ-009 FIXED mode: g = sel; if sel >= N or in_valid[sel]=0, there SHALL be no grant.
REQ-010 ROUND_ROBIN mode: g = first k with in_valid[k]=1, searching ptr, ptr+1, ... modulo N; if no valid bit is set, there SHALL be no grant.
REQ-011 ptr (SELW bits) SHALL become (g+1) mod N on every ROUND_ROBIN transfer, and SHALL wrap N-1 -> 0 for non-power-of-two N.
REQ-012 ptr SHALL hold when there is no transfer, and in FIXED mode.
REQ-013 While out_valid=1 and out_ready=0, out_data and out_ch SHALL hold, and in_ready SHALL be all zero.
REQ-014 When out_valid=1, out_ready=1 and there is no grant, out_valid SHALL fall to 0 at the next edge.
REQ-015 A change of mode or sel SHALL take effect on the same cycle's grant (combinational selection, registered output); no word in flight is lost or duplicated.
REQ-016 in_ready SHALL depend only on in_valid, mode, sel, ptr and load, never on in_data.

Reset
REQ-017 While rst=1 at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-018 in_ready SHALL be all zero during every cycle in which rst=1.
REQ-019 Reset mid-transfer SHALL discard the held word; the first grant after reset SHALL search from channel 0.

Structure
REQ-020 The shared package SHALL hold the MODE_FIXED=0 / MODE_RR=1 constants and the clog2 function.
REQ-021 The rotating priority search SHALL be one sub-module, rr_prio_enc (inputs: req[N], ptr; outputs: gnt_idx, gnt_any), purely combinational.
REQ-022 The top level SHALL hold only the ptr register, the output register and the load/handshake logic.

Verification
REQ-023 Reset then FIXED mode, N=16, W=8, in_data[k]=k*17, sel=7, all valid, out_ready=1 -> in_ready=0x0080; next cycle out_data=0x77, out_ch=7, out_valid=1.
REQ-024 ROUND_ROBIN mode, all 16 valid, out_ready=1 for 20 cycles -> out_ch sequence 0,1,...,15,0,1,2,3 with no gaps.
REQ-025 ROUND_ROBIN mode, only channels 3 and 12 valid -> out_ch alternates 3,12,3,12; ptr wraps correctly through 13 -> 3.
REQ-026 Word held with out_ready=0 for 5 cycles, in_valid toggling -> out_data/out_ch stable, in_ready=0; the word releases on the first out_ready=1.
REQ-027 N=5, FIXED mode, sel=6 -> no grant, out_valid stays 0; ROUND_ROBIN with only channel 4 valid -> ptr wraps to 0.
REQ-028 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0; the first RR grant after reset is the lowest valid channel.
